// File: rtl/answer_checker_pkg.sv
// answer_checker_pkg: op codes, key codes, score limit and FSM states shared by the quiz checker
package answer_checker_pkg;
  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;
  localparam logic [6:0] SCORE_MAX = 7'd99;
  typedef enum logic [1:0] {IDLE, EVAL, WAIT, CHECK} state_t;
endpackage

// File: rtl/answer_checker_expr_eval.sv
// expr_eval: combinational evaluation of {num1, op, num2}, result truncated to 7 bits
module expr_eval
  import answer_checker_pkg::*;
(
  input  logic [11:0] exp_q,
  output logic [6:0]  result,
  output logic        valid
);
  logic [3:0] op;
  logic [7:0] a, b, r;
  assign op = exp_q[7:4];
  assign a = {4'b0, exp_q[11:8]};
  assign b = {4'b0, exp_q[3:0]};
  assign r = op == OP_ADD ? a + b :
             op == OP_SUB ? (a >= b ? a - b : b - a) :
             op == OP_MUL ? a * b :
             op == OP_DIV ? (b == 8'd0 ? 8'd0 : a / b) : 8'd0;
  assign result = r[6:0];
  assign valid = op >= OP_ADD && op <= OP_DIV;
endmodule

// File: rtl/answer_checker.sv
// answer_checker: latches an arithmetic question, collects keypad digits and scores the answer
module answer_checker
  import answer_checker_pkg::*;
#(
  parameter int TIMER_W = 27,
  parameter logic [TIMER_W-1:0] TIME_LIMIT = 27'd100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] exp,
  input  logic        start,
  input  logic [3:0]  key,
  input  logic        key_valid,
  output logic [6:0]  score,
  output logic [6:0]  entry,
  output logic        busy,
  output logic        correct,
  output logic        wrong,
  output logic        timeout,
  output logic        bad_exp,
  output logic        req_next
);
  state_t state, state_n;
  logic [11:0] exp_q;
  logic [6:0] answer_q, result;
  logic valid, to_q, is_enter, is_clear, is_digit, expired, hit;
  logic [1:0] cnt;
  logic [TIMER_W-1:0] timer;
  expr_eval u_eval (.exp_q(exp_q), .result(result), .valid(valid));
  assign is_enter = key_valid && key == KEY_ENTER && cnt != 2'd0;
  assign is_clear = key_valid && key == KEY_CLEAR;
  assign is_digit = key_valid && key <= 4'd9 && cnt < 2'd2;
  assign expired = timer == TIME_LIMIT - 1'b1;
  assign hit = entry == answer_q && !to_q;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? EVAL : IDLE;
      EVAL:    state_n = valid ? WAIT : IDLE;
      WAIT:    state_n = is_enter || expired ? CHECK : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      exp_q <= '0;
      answer_q <= '0;
      entry <= '0;
      score <= '0;
      cnt <= '0;
      timer <= '0;
      to_q <= 1'b0;
      correct <= 1'b0;
      wrong <= 1'b0;
      timeout <= 1'b0;
      bad_exp <= 1'b0;
      req_next <= 1'b0;
    end else begin
      state <= state_n;
      correct <= 1'b0;
      wrong <= 1'b0;
      timeout <= 1'b0;
      bad_exp <= 1'b0;
      req_next <= 1'b0;
      case (state)
        IDLE: if (start) begin
          exp_q <= exp;
          entry <= '0;
          cnt <= '0;
          timer <= '0;
          to_q <= 1'b0;
        end
        EVAL: begin
          answer_q <= result;
          bad_exp <= !valid;
          req_next <= !valid;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // enter beats a simultaneous expiry; keys are dropped once the timer forces CHECK
          if (!is_enter && expired) to_q <= 1'b1;
          else if (!is_enter && is_clear) begin
            entry <= '0;
            cnt <= '0;
          end else if (!is_enter && is_digit) begin
            entry <= entry * 7'd10 + {3'b0, key};
            cnt <= cnt + 2'd1;
          end
        end
        CHECK: begin
          correct <= hit;
          wrong <= !hit;
          timeout <= to_q;
          req_next <= 1'b1;
          score <= hit ? (score == SCORE_MAX ? score : score + 7'd1) : (score == 7'd0 ? score : score - 7'd1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/answer_checker.md
ANSWER_CHECKER -- requirements
Module: answer_checker

Interface
REQ-001 Parameter TIME_LIMIT, default 27'd100_000_000, cycles allowed per question before timeout.
REQ-002 Parameter TIMER_W, default 27, width of the question timer.
REQ-003 clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 exp  input  12  expression {num1[11:8], op[7:4], num2[3:0]}; ops 4'hA add, 4'hB subtract, 4'hC multiply, 4'hD divide.
REQ-006 start  input  1  one-cycle request to latch exp and begin a question.
REQ-007 key  input  4  keypad code: 0-9 digit, 4'hE enter, 4'hF clear, 4'hA-4'hD ignored.
REQ-008 key_valid  input  1  one-cycle strobe qualifying key.
REQ-009 score  output  7  running score, 0..99.
REQ-010 entry  output  7  player's current entered value, binary, 0..99.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 correct  output  1  one-cycle pulse on a right answer.
REQ-013 wrong  output  1  one-cycle pulse on a wrong answer or timeout.
REQ-014 timeout  output  1  one-cycle pulse, coincident with wrong, when the timer expired.
REQ-015 bad_exp  output  1  one-cycle pulse when a latched op is not 4'hA-4'hD.
REQ-016 req_next  output  1  one-cycle pulse requesting a new expression, issued on leaving CHECK or on bad_exp.

Function
REQ-017 The FSM SHALL have states IDLE, EVAL, WAIT, CHECK.
REQ-018 IDLE: start=1 -> exp_q<=exp, entry<=0, digit count<=0, timer<=0, go EVAL; start in any other state is ignored.
REQ-019 EVAL (one cycle): answer_q<=eval(exp_q), go WAIT; invalid op -> pulse bad_exp and req_next, go IDLE, score unchanged.
REQ-020 Evaluation: add = num1+num2; subtract = num1-num2 if num1>=num2 else num2-num1; multiply = num1*num2; divide = integer floor(num1/num2), defined 0 when num2=0; result 7 bits, max 81 for operands 0..9.
REQ-021 Operand nibbles above 9 are used as-is (mod-16 arithmetic truncated to 7 bits); no error raised.
REQ-022 WAIT digit: if digit count<2, entry<=entry*10+digit and count++; third and later digits ignored.
REQ-023 WAIT clear (4'hF): entry<=0, count<=0; timer keeps running.
REQ-024 WAIT enter (4'hE) with count=0 is ignored; with count>=1 go CHECK.
REQ-025 Timer increments every WAIT cycle; reaching TIME_LIMIT-1 forces CHECK with the timeout flag set.
REQ-026 Enter and timer expiry in the same cycle: enter wins, timeout flag not set.
REQ-027 CHECK (one cycle): entry==answer_q and no timeout -> correct pulse, score+1 saturating at 99; otherwise wrong pulse (plus timeout pulse if timed out), score-1 saturating at 0; req_next pulse; go IDLE.
REQ-028 Output pulses SHALL be registered and appear in the cycle after the CHECK/EVAL decision edge; no output is combinational from inputs.
REQ-029 key_valid outside WAIT is ignored; entry holds its last value in IDLE for display.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, score=0, entry=0, busy=0, all pulses 0, exp_q=0, answer_q=0, timer=0, regardless of clock.
REQ-031 Reset mid-question SHALL discard the question without any correct/wrong/req_next pulse.

Structure
REQ-032 A shared package SHALL hold op codes (OP_ADD..OP_DIV), key codes (KEY_ENTER, KEY_CLEAR), SCORE_MAX=99 and the state enum.
REQ-033 Evaluation SHALL live in a combinational sub-module expr_eval (exp_q in, 7-bit result and valid flag out).

Verification (TIME_LIMIT=20)
REQ-034 exp=12'h3A4, start, keys 7,E -> correct pulse, score 0->1, req_next pulse.
REQ-035 exp=12'h9C9, start, keys 8,1,5,E -> third digit ignored, entry=81, correct.
REQ-036 exp=12'h2B7, start, keys 5,E with score 0 -> correct (|2-7|=5); then exp=12'h7D2, keys 4,E -> wrong (answer 3), score 1->0.
REQ-037 exp=12'h5A5, start, no keys for 20 cycles -> wrong and timeout pulses together, score stays 0 at floor.
REQ-038 exp=12'h1E1, start -> bad_exp and req_next pulses two cycles later, busy returns 0, score unchanged.
REQ-039 Score preset to 99 via 99 correct answers, one more correct -> score stays 99; assert rst mid-WAIT -> score 0, no pulses.
